mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Single-port RAM arbiter sharing the CPU8 program/data memory between the CPU fetch/load/store path and a debug/program-loader port. Grants one access at a time over a req/gnt handshake and returns read data with a valid strobe. Supports an exclusive loader lock that stalls the CPU clock gate, in the same way HALT gates the 1 Hz core clock. Sits between the CPU core, the host loader and the RAM.

## Interface
- STARVE_MAX, 4: consecutive CPU grants allowed while dbg_req waits; range 1–15.
- PROT_TOP, 8'h0F: highest CPU-write-protected address; used only with MEM_ARB_WRPROT_EN.

- CLK  in  1  system clock, 50 MHz domain.
- CLR  in  1  synchronous, active-high reset.
- cpu_req / cpu_we  in  1 / 1  CPU access request / write select.
- cpu_addr / cpu_wdata  in  8 / 8  CPU address / write data (Dout_ACC for ST).
- cpu_gnt  out  1  one-cycle grant pulse.
- cpu_rdata / cpu_rvalid  out  8 / 1  read data / one-cycle valid.
- dbg_req / dbg_we / dbg_lock  in  1 / 1 / 1  loader request / write select / exclusive-ownership request.
- dbg_addr / dbg_wdata  in  8 / 8  loader address / write data.
- dbg_gnt / dbg_rdata / dbg_rvalid  out  1 / 8 / 1  loader grant / read data / valid.
- ram_addr / ram_din / ram_we  out  8 / 8 / 1  registered RAM bus; ram_we is active-high.
- ram_dout  in  8  RAM read data, valid one cycle after ram_addr is presented.
- cpu_stall  out  1  high while the loader owns memory; gates the CPU clock.
- wp_err  out  1  one-cycle pulse on a blocked CPU write.

## Operation
- States: IDLE, ISSUE, RDWAIT, LOCKED, LK_ISSUE, LK_RDWAIT.
- IDLE arbitration:
  - dbg_lock=1 → LOCKED; cpu_stall=1 from the next cycle.
  - Otherwise, if starve_cnt==STARVE_MAX and dbg_req → loader wins.
  - Otherwise cpu_req has priority over dbg_req.
- Winner: gnt pulse; ram_addr, ram_din and ram_we are registered from the winner's inputs → ISSUE.
- Leaving ISSUE: read → RDWAIT. Write → IDLE.
- RDWAIT: ram_dout is captured into the winner's rdata; rvalid pulses; → IDLE.
- Starvation counter: increments on each CPU grant while dbg_req=1. Clears on any dbg grant or when dbg_req=0. Saturates at STARVE_MAX.
- LOCKED:
  - Only dbg requests are served, through LK_ISSUE and LK_RDWAIT.
  - cpu_req is ignored and never granted.
  - Exit to IDLE when dbg_lock=0 and no access is in flight; cpu_stall falls the cycle after exit.
- dbg_lock asserted mid-access: the in-flight access completes normally before LOCKED is entered.
- ram_we is high only in ISSUE and LK_ISSUE. It is 0 in every other state.
- Requesters hold req, we, addr and wdata stable until they sample gnt, then drop req. req is sampled only in IDLE and LOCKED.

## Timing
- Request asserted in cycle 0 → gnt, ram_* driven in cycle 1 → RAM captures at the edge ending cycle 1.
- Read: rvalid and rdata in cycle 3. Write: committed at the end of cycle 1.
- Throughput: one write per 2 cycles; one read per 3 cycles.
- Simultaneous cpu_req and dbg_req: CPU wins unless the starvation count has been reached.
- Reset: CLR sampled high → next cycle state=IDLE, all outputs 0, starve_cnt=0. An in-flight access is abandoned and the read strobe is suppressed.
- rdata holds its last value until the next read for that port.

## Configuration
- MEM_ARB_WRPROT_EN defined:
  - A CPU write with cpu_addr ≤ PROT_TOP is granted normally (gnt pulses).
  - ram_we stays 0 for that access.
  - wp_err pulses in the ISSUE cycle.
  - Loader writes are never blocked.
- Undefined: wp_err is tied 0, PROT_TOP is ignored, and all CPU writes commit.

## Structure
- Package mem_arb_pkg holds:
  - the state enum;
  - the requester-id enum (REQ_CPU, REQ_DBG);
  - the starvation-counter width constant.
- Sub-module mem_arb_starve_cnt holds the saturating starvation counter, with inc/clr/sat ports.

## Test plan
- CPU read at 8'h05 with RAM[5]=8'h3C → cpu_gnt in cycle 1, cpu_rvalid and cpu_rdata=8'h3C in cycle 3.
- cpu_req and dbg_req held continuously, STARVE_MAX=4 → grant order CPU×4, DBG, CPU×4, DBG.
- dbg_lock asserted during a CPU read → CPU read completes; cpu_stall=1 afterwards; loader writes 8'hAA to 8'h20; cpu_req gets no gnt until lock release; cpu_stall=0 one cycle after exit.
- MEM_ARB_WRPROT_EN, CPU write of 8'h77 to 8'h03 → cpu_gnt=1, ram_we=0, wp_err pulse, RAM[3] unchanged; a write to 8'h10 commits.
- CLR asserted during RDWAIT → no rvalid; all outputs 0 next cycle; the next request is served with cycle-0 timing.

Source files
------------

// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// mem_arb_pkg : shared types and constants for the CPU8 memory arbiter
// Rev 1.0
// ============================================================================
package mem_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_RDWAIT    = 3'd2,
    ST_LOCKED    = 3'd3,
    ST_LK_ISSUE  = 3'd4,
    ST_LK_RDWAIT = 3'd5
  } arb_state_e;

  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_DBG = 1'b1
  } req_id_e;

  localparam int STARVE_CNT_W = 4;

endpackage
`default_nettype wire

// File: rtl/mem_arb_starve_cnt.sv
`default_nettype none
// ============================================================================
// mem_arb_starve_cnt : saturating count of CPU grants while the loader waits
// Rev 1.0
// ============================================================================
module mem_arb_starve_cnt
  import mem_arb_pkg::*;
#(
  parameter int MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  localparam logic [STARVE_CNT_W-1:0] C_MAX = STARVE_CNT_W'(MAX);

  logic [STARVE_CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != C_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign sat = (cnt_q == C_MAX);

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// mem_arbiter : single-port RAM arbiter between CPU8 core and loader port
// Optional CPU write protection below PROT_TOP: define MEM_ARB_WRPROT_EN
// Rev 1.0
// ============================================================================
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int         STARVE_MAX = 4,
  parameter logic [7:0] PROT_TOP   = 8'h0F
) (
  input  logic       CLK,
  input  logic       CLR,
  input  logic       cpu_req,
  input  logic       cpu_we,
  input  logic [7:0] cpu_addr,
  input  logic [7:0] cpu_wdata,
  output logic       cpu_gnt,
  output logic [7:0] cpu_rdata,
  output logic       cpu_rvalid,
  input  logic       dbg_req,
  input  logic       dbg_we,
  input  logic       dbg_lock,
  input  logic [7:0] dbg_addr,
  input  logic [7:0] dbg_wdata,
  output logic       dbg_gnt,
  output logic [7:0] dbg_rdata,
  output logic       dbg_rvalid,
  output logic [7:0] ram_addr,
  output logic [7:0] ram_din,
  output logic       ram_we,
  input  logic [7:0] ram_dout,
  output logic       cpu_stall,
  output logic       wp_err
);

`ifdef MEM_ARB_WRPROT_EN
  localparam bit C_WRPROT_EN = 1'b1;
`else
  localparam bit C_WRPROT_EN = 1'b0;
`endif

  arb_state_e state_q, state_d;
  req_id_e    owner_q, owner_d;
  logic       acc_we_q, acc_we_d;
  logic [7:0] ram_addr_q, ram_addr_d, ram_din_q, ram_din_d;
  logic       ram_we_q, ram_we_d;
  logic       cpu_gnt_q, cpu_gnt_d, dbg_gnt_q, dbg_gnt_d;
  logic       cpu_rvalid_q, cpu_rvalid_d, dbg_rvalid_q, dbg_rvalid_d;
  logic [7:0] cpu_rdata_q, cpu_rdata_d, dbg_rdata_q, dbg_rdata_d;
  logic       wp_err_q, wp_err_d;
  logic       take_cpu, take_dbg, cnt_inc, cnt_clr, starve_sat;
  logic       wp_block;

  // A protected CPU write is still granted; only the RAM strobe is withheld.
  assign wp_block = C_WRPROT_EN && cpu_we && (cpu_addr <= PROT_TOP);

  mem_arb_starve_cnt #(
    .MAX (STARVE_MAX)
  ) u_starve_cnt (
    .clk (CLK),
    .rst (CLR),
    .inc (cnt_inc),
    .clr (cnt_clr),
    .sat (starve_sat)
  );

  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_q      <= ST_IDLE;
      owner_q      <= REQ_CPU;
      acc_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_din_q    <= '0;
      ram_we_q     <= 1'b0;
      cpu_gnt_q    <= 1'b0;
      dbg_gnt_q    <= 1'b0;
      cpu_rvalid_q <= 1'b0;
      dbg_rvalid_q <= 1'b0;
      cpu_rdata_q  <= '0;
      dbg_rdata_q  <= '0;
      wp_err_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      acc_we_q     <= acc_we_d;
      ram_addr_q   <= ram_addr_d;
      ram_din_q    <= ram_din_d;
      ram_we_q     <= ram_we_d;
      cpu_gnt_q    <= cpu_gnt_d;
      dbg_gnt_q    <= dbg_gnt_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      dbg_rvalid_q <= dbg_rvalid_d;
      cpu_rdata_q  <= cpu_rdata_d;
      dbg_rdata_q  <= dbg_rdata_d;
      wp_err_q     <= wp_err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    acc_we_d     = acc_we_q;
    ram_addr_d   = ram_addr_q;
    ram_din_d    = ram_din_q;
    ram_we_d     = 1'b0;
    cpu_gnt_d    = 1'b0;
    dbg_gnt_d    = 1'b0;
    cpu_rvalid_d = 1'b0;
    dbg_rvalid_d = 1'b0;
    cpu_rdata_d  = cpu_rdata_q;
    dbg_rdata_d  = dbg_rdata_q;
    wp_err_d     = 1'b0;
    take_cpu     = 1'b0;
    take_dbg     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (dbg_lock) begin
          state_d = ST_LOCKED;
        end else if (dbg_req && (starve_sat || !cpu_req)) begin
          take_dbg = 1'b1;
          state_d  = ST_ISSUE;
        end else if (cpu_req) begin
          take_cpu = 1'b1;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE:    state_d = acc_we_q ? ST_IDLE : ST_RDWAIT;
      ST_RDWAIT: begin
        if (owner_q == REQ_CPU) begin
          cpu_rdata_d  = ram_dout;
          cpu_rvalid_d = 1'b1;
        end else begin
          dbg_rdata_d  = ram_dout;
          dbg_rvalid_d = 1'b1;
        end
        state_d = ST_IDLE;
      end
      ST_LOCKED: begin
        if (dbg_req) begin
          take_dbg = 1'b1;
          state_d  = ST_LK_ISSUE;
        end else if (!dbg_lock) begin
          state_d = ST_IDLE;
        end
      end
      ST_LK_ISSUE: state_d = acc_we_q ? ST_LOCKED : ST_LK_RDWAIT;
      ST_LK_RDWAIT: begin
        dbg_rdata_d  = ram_dout;
        dbg_rvalid_d = 1'b1;
        state_d      = ST_LOCKED;
      end
      default:     state_d = ST_IDLE;
    endcase

    if (take_dbg) begin
      dbg_gnt_d  = 1'b1;
      owner_d    = REQ_DBG;
      acc_we_d   = dbg_we;
      ram_addr_d = dbg_addr;
      ram_din_d  = dbg_wdata;
      ram_we_d   = dbg_we;
    end
    if (take_cpu) begin
      cpu_gnt_d  = 1'b1;
      owner_d    = REQ_CPU;
      acc_we_d   = cpu_we;
      ram_addr_d = cpu_addr;
      ram_din_d  = cpu_wdata;
      ram_we_d   = cpu_we && !wp_block;
      wp_err_d   = wp_block;
    end
  end

  // Counter only advances while the loader is actually waiting.
  assign cnt_inc = take_cpu && dbg_req;
  assign cnt_clr = take_dbg || !dbg_req;

  always_comb begin
    cpu_stall = 1'b0;
    case (state_q)
      ST_LOCKED, ST_LK_ISSUE, ST_LK_RDWAIT: cpu_stall = 1'b1;
      default:                              cpu_stall = 1'b0;
    endcase
  end

  assign cpu_gnt    = cpu_gnt_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign cpu_rvalid = cpu_rvalid_q;
  assign dbg_gnt    = dbg_gnt_q;
  assign dbg_rdata  = dbg_rdata_q;
  assign dbg_rvalid = dbg_rvalid_q;
  assign ram_addr   = ram_addr_q;
  assign ram_din    = ram_din_q;
  assign ram_we     = ram_we_q;
  assign wp_err     = C_WRPROT_EN ? wp_err_q : 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mem_arbiter : directed self-checking bench for mem_arbiter with RAM model
// Rev 1.0
// ============================================================================
module tb_mem_arbiter;

  logic       CLK = 1'b0;
  logic       CLR = 1'b1;
  logic       cpu_req = 1'b0, cpu_we = 1'b0;
  logic [7:0] cpu_addr = '0, cpu_wdata = '0;
  logic       cpu_gnt, cpu_rvalid;
  logic [7:0] cpu_rdata;
  logic       dbg_req = 1'b0, dbg_we = 1'b0, dbg_lock = 1'b0;
  logic [7:0] dbg_addr = '0, dbg_wdata = '0;
  logic       dbg_gnt, dbg_rvalid;
  logic [7:0] dbg_rdata;
  logic [7:0] ram_addr, ram_din, ram_dout;
  logic       ram_we, cpu_stall, wp_err;

  logic [7:0] mem [0:255];
  logic       bd_we = 1'b0;
  logic [7:0] bd_addr = '0, bd_data = '0;

  int n_checks = 0;
  int n_errors = 0;

  logic [38:0] outs;
  assign outs = {cpu_gnt, cpu_rdata, cpu_rvalid, dbg_gnt, dbg_rdata, dbg_rvalid,
                 ram_addr, ram_din, ram_we, cpu_stall, wp_err};

  always #10 CLK = ~CLK;

  // Synchronous RAM: registered read, write on ram_we; backdoor for preload.
  always @(posedge CLK) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  mem_arbiter #(
    .STARVE_MAX (4),
    .PROT_TOP   (8'h0F)
  ) dut (
    .CLK        (CLK),
    .CLR        (CLR),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_gnt    (cpu_gnt),
    .cpu_rdata  (cpu_rdata),
    .cpu_rvalid (cpu_rvalid),
    .dbg_req    (dbg_req),
    .dbg_we     (dbg_we),
    .dbg_lock   (dbg_lock),
    .dbg_addr   (dbg_addr),
    .dbg_wdata  (dbg_wdata),
    .dbg_gnt    (dbg_gnt),
    .dbg_rdata  (dbg_rdata),
    .dbg_rvalid (dbg_rvalid),
    .ram_addr   (ram_addr),
    .ram_din    (ram_din),
    .ram_we     (ram_we),
    .ram_dout   (ram_dout),
    .cpu_stall  (cpu_stall),
    .wp_err     (wp_err)
  );

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    cyc();
    bd_we = 1'b0;
  endtask

  task automatic test_reset();
    CLR = 1'b1;
    poke(8'h05, 8'h3C);
    poke(8'h06, 8'h5A);
    poke(8'h03, 8'h99);
    poke(8'h10, 8'h00);
    n_checks++;
    if (outs !== '0) begin
      n_errors++; $display("FAIL reset_outputs: got %h expected 0", outs);
    end
    CLR = 1'b0;
    cyc();
    n_checks++;
    if (outs !== '0) begin
      n_errors++; $display("FAIL idle_outputs: got %h expected 0", outs);
    end
  endtask

  task automatic test_cpu_read();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h05;
    cyc();
    n_checks++;
    if ({cpu_gnt, dbg_gnt, ram_we, ram_addr} !== {1'b1, 1'b0, 1'b0, 8'h05}) begin
      n_errors++; $display("FAIL rd_grant: got %b%b%b %h expected 100 05", cpu_gnt, dbg_gnt, ram_we, ram_addr);
    end
    cpu_req = 1'b0;
    cyc();
    n_checks++;
    if ({cpu_gnt, cpu_rvalid} !== 2'b00) begin
      n_errors++; $display("FAIL rd_cycle2: got gnt=%b rvalid=%b expected 0 0", cpu_gnt, cpu_rvalid);
    end
    cyc();
    n_checks++;
    if ({cpu_rvalid, cpu_rdata} !== {1'b1, 8'h3C}) begin
      n_errors++; $display("FAIL rd_data: got rvalid=%b rdata=%h expected 1 3c", cpu_rvalid, cpu_rdata);
    end
    cyc();
    n_checks++;
    if ({cpu_rvalid, cpu_rdata} !== {1'b0, 8'h3C}) begin
      n_errors++; $display("FAIL rd_hold: got rvalid=%b rdata=%h expected 0 3c", cpu_rvalid, cpu_rdata);
    end
  endtask

  task automatic test_back_to_back();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h40; cpu_wdata = 8'h11;
    cyc();
    n_checks++;
    if ({cpu_gnt, ram_we, ram_addr, ram_din} !== {1'b1, 1'b1, 8'h40, 8'h11}) begin
      n_errors++; $display("FAIL wr1_issue: got %b%b %h %h expected 11 40 11", cpu_gnt, ram_we, ram_addr, ram_din);
    end
    cpu_addr = 8'h41; cpu_wdata = 8'h22;
    cyc();
    n_checks++;
    if ({cpu_gnt, ram_we} !== 2'b00) begin
      n_errors++; $display("FAIL wr_gap: got gnt=%b we=%b expected 0 0", cpu_gnt, ram_we);
    end
    cyc();
    n_checks++;
    if ({cpu_gnt, ram_we, ram_addr, ram_din} !== {1'b1, 1'b1, 8'h41, 8'h22}) begin
      n_errors++; $display("FAIL wr2_issue: got %b%b %h %h expected 11 41 22", cpu_gnt, ram_we, ram_addr, ram_din);
    end
    cpu_req = 1'b0; cpu_we = 1'b0;
    cyc();
    n_checks++;
    if ({mem[8'h40], mem[8'h41], ram_we} !== {8'h11, 8'h22, 1'b0}) begin
      n_errors++; $display("FAIL wr_commit: got %h %h we=%b expected 11 22 0", mem[8'h40], mem[8'h41], ram_we);
    end
  endtask

  task automatic test_starve();
    logic [9:0] seq = '0;
    logic       both = 1'b0;
    int         ng = 0;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h50; cpu_wdata = 8'hA1;
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 8'h60; dbg_wdata = 8'hB2;
    for (int c = 0; c < 40 && ng < 10; c++) begin
      cyc();
      if (cpu_gnt && dbg_gnt) both = 1'b1;
      if (cpu_gnt) begin
        seq[ng] = 1'b0; ng++;
      end else if (dbg_gnt) begin
        seq[ng] = 1'b1; ng++;
      end
    end
    cpu_req = 1'b0; cpu_we = 1'b0; dbg_req = 1'b0; dbg_we = 1'b0;
    cyc();
    cyc();
    n_checks++;
    if (ng != 10) begin
      n_errors++; $display("FAIL starve_count: got %0d grants expected 10", ng);
    end
    n_checks++;
    if (seq !== 10'b10000_10000) begin
      n_errors++; $display("FAIL starve_order: got %b expected 1000010000 (bit0 first, 1=DBG)", seq);
    end
    n_checks++;
    if ({both, mem[8'h60]} !== {1'b0, 8'hB2}) begin
      n_errors++; $display("FAIL starve_dbg_wr: got both=%b mem=%h expected 0 b2", both, mem[8'h60]);
    end
  endtask

  task automatic test_lock();
    logic saw_gnt = 1'b0;
    logic lost_stall = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h05;
    cyc();
    cpu_req = 1'b0; dbg_lock = 1'b1;
    cyc();
    n_checks++;
    if (cpu_stall !== 1'b0) begin
      n_errors++; $display("FAIL lock_inflight_stall: got %b expected 0", cpu_stall);
    end
    cyc();
    n_checks++;
    if ({cpu_rvalid, cpu_rdata, cpu_stall} !== {1'b1, 8'h3C, 1'b0}) begin
      n_errors++; $display("FAIL lock_rd_done: got rvalid=%b rdata=%h stall=%b expected 1 3c 0", cpu_rvalid, cpu_rdata, cpu_stall);
    end
    cpu_req = 1'b1; cpu_addr = 8'h06;
    cyc();
    n_checks++;
    if ({cpu_stall, cpu_gnt} !== 2'b10) begin
      n_errors++; $display("FAIL lock_enter: got stall=%b gnt=%b expected 1 0", cpu_stall, cpu_gnt);
    end
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 8'h20; dbg_wdata = 8'hAA;
    cyc();
    n_checks++;
    if ({dbg_gnt, cpu_gnt, ram_we, ram_addr, ram_din} !== {1'b1, 1'b0, 1'b1, 8'h20, 8'hAA}) begin
      n_errors++; $display("FAIL lock_dbg_wr: got %b%b%b %h %h expected 101 20 aa", dbg_gnt, cpu_gnt, ram_we, ram_addr, ram_din);
    end
    dbg_req = 1'b0; dbg_we = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      if (cpu_gnt) saw_gnt = 1'b1;
      if (!cpu_stall) lost_stall = 1'b1;
    end
    n_checks++;
    if ({saw_gnt, lost_stall, mem[8'h20]} !== {1'b0, 1'b0, 8'hAA}) begin
      n_errors++; $display("FAIL lock_hold: got cpu_gnt_seen=%b stall_dropped=%b mem=%h expected 0 0 aa", saw_gnt, lost_stall, mem[8'h20]);
    end
    dbg_lock = 1'b0;
    cyc();
    n_checks++;
    if ({cpu_stall, cpu_gnt} !== 2'b00) begin
      n_errors++; $display("FAIL lock_exit: got stall=%b gnt=%b expected 0 0", cpu_stall, cpu_gnt);
    end
    cyc();
    n_checks++;
    if ({cpu_gnt, ram_addr} !== {1'b1, 8'h06}) begin
      n_errors++; $display("FAIL lock_cpu_resume: got gnt=%b addr=%h expected 1 06", cpu_gnt, ram_addr);
    end
    cpu_req = 1'b0;
    cyc();
    cyc();
    n_checks++;
    if ({cpu_rvalid, cpu_rdata} !== {1'b1, 8'h5A}) begin
      n_errors++; $display("FAIL lock_cpu_rd: got rvalid=%b rdata=%h expected 1 5a", cpu_rvalid, cpu_rdata);
    end
    cyc();
  endtask

  task automatic test_wrprot();
`ifdef MEM_ARB_WRPROT_EN
    logic [2:0] exp_issue = 3'b101;
    logic [7:0] exp_mem3  = 8'h99;
`else
    logic [2:0] exp_issue = 3'b110;
    logic [7:0] exp_mem3  = 8'h77;
`endif
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h03; cpu_wdata = 8'h77;
    cyc();
    n_checks++;
    if ({cpu_gnt, ram_we, wp_err} !== exp_issue) begin
      n_errors++; $display("FAIL wp_low_issue: got gnt/we/err=%b%b%b expected %b", cpu_gnt, ram_we, wp_err, exp_issue);
    end
    cpu_req = 1'b0; cpu_we = 1'b0;
    cyc();
    n_checks++;
    if ({wp_err, mem[8'h03]} !== {1'b0, exp_mem3}) begin
      n_errors++; $display("FAIL wp_low_mem: got err=%b mem=%h expected 0 %h", wp_err, mem[8'h03], exp_mem3);
    end
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h10; cpu_wdata = 8'h66;
    cyc();
    n_checks++;
    if ({cpu_gnt, ram_we, wp_err} !== 3'b110) begin
      n_errors++; $display("FAIL wp_high_issue: got gnt/we/err=%b%b%b expected 110", cpu_gnt, ram_we, wp_err);
    end
    cpu_req = 1'b0; cpu_we = 1'b0;
    cyc();
    n_checks++;
    if (mem[8'h10] !== 8'h66) begin
      n_errors++; $display("FAIL wp_high_mem: got %h expected 66", mem[8'h10]);
    end
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 8'h03; dbg_wdata = 8'h55;
    cyc();
    n_checks++;
    if ({dbg_gnt, ram_we, wp_err} !== 3'b110) begin
      n_errors++; $display("FAIL wp_dbg_issue: got gnt/we/err=%b%b%b expected 110", dbg_gnt, ram_we, wp_err);
    end
    dbg_req = 1'b0; dbg_we = 1'b0;
    cyc();
    n_checks++;
    if (mem[8'h03] !== 8'h55) begin
      n_errors++; $display("FAIL wp_dbg_mem: got %h expected 55", mem[8'h03]);
    end
  endtask

  task automatic test_reset_mid_read();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h05;
    cyc();
    cpu_req = 1'b0;
    cyc();
    CLR = 1'b1;
    cyc();
    n_checks++;
    if (outs !== '0) begin
      n_errors++; $display("FAIL clr_mid_read: got %h expected 0", outs);
    end
    CLR = 1'b0;
    cpu_req = 1'b1; cpu_addr = 8'h06;
    cyc();
    n_checks++;
    if ({cpu_gnt, ram_addr} !== {1'b1, 8'h06}) begin
      n_errors++; $display("FAIL clr_next_gnt: got gnt=%b addr=%h expected 1 06", cpu_gnt, ram_addr);
    end
    cpu_req = 1'b0;
    cyc();
    n_checks++;
    if (cpu_rvalid !== 1'b0) begin
      n_errors++; $display("FAIL clr_next_early: got rvalid=%b expected 0", cpu_rvalid);
    end
    cyc();
    n_checks++;
    if ({cpu_rvalid, cpu_rdata} !== {1'b1, 8'h5A}) begin
      n_errors++; $display("FAIL clr_next_rd: got rvalid=%b rdata=%h expected 1 5a", cpu_rvalid, cpu_rdata);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    test_reset();
    test_cpu_read();
    test_back_to_back();
    test_starve();
    test_lock();
    test_wrprot();
    test_reset_mid_read();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
